pipe_stage_skid: RTL and testbench

- Parametrised, elastic pipeline stage register for inter-stage boundaries (MEM->WB, EX->MEM, ...).
- Replaces free-running capture registers with:
  - valid/ready handshake,
  - 2-entry skid buffer, so throughput stays at 1 beat/cycle under backpressure,
  - synchronous flush that inserts a bubble,
  - saturating stall-cycle counter for performance debug.

---
 rtl/pipe_stage_skid.sv | 132 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register with a two-entry skid buffer.
//
// Sits on an inter-stage boundary (EX->MEM, MEM->WB, ...). It accepts one beat
// per cycle and issues one beat per cycle, even while the downstream stage is
// applying backpressure.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   flush                synchronous kill of all held beats; inserts a bubble
//   in_valid, in_data    upstream beat
//   in_ready             stage can take a beat this cycle (decoded from state only)
//   out_valid, out_data  downstream beat; out_data is BUBBLE_VAL while out_valid=0
//   out_ready            downstream accepts the beat
//   cnt_clr              synchronous clear of stall_cnt
//   stall_cnt            saturating count of cycles with out_valid & !out_ready
//   occupancy            number of beats held (0..2)
module pipe_stage_skid #(
  parameter int unsigned       DATA_W     = 102,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        occupancy
);

  // Encoding equals the number of beats held, so occupancy is the state itself.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic accept;
  logic issue;

  // Handshake outputs depend on the state register only; out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (state_q != StSkid);
  assign out_valid = (state_q != StEmpty);
  assign out_data  = out_valid ? main_q : BUBBLE_VAL;
  assign occupancy = state_q;
  assign stall_cnt = cnt_q;

  assign accept = in_valid & in_ready;
  assign issue  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = in_data;
          state_d = StFull;
        end
      end
      StFull: begin
        if (issue && accept) begin
          main_d = in_data;
        end else if (issue) begin
          state_d = StEmpty;
        end else if (accept) begin
          // Downstream stalled: park the new beat behind the one on display.
          skid_d  = in_data;
          state_d = StSkid;
        end
      end
      StSkid: begin
        if (issue) begin
          main_d  = skid_q;
          skid_d  = BUBBLE_VAL;
          state_d = StFull;
        end
      end
      default: begin
        state_d = StEmpty;
        main_d  = BUBBLE_VAL;
        skid_d  = BUBBLE_VAL;
      end
    endcase

    // Flush wins over everything; a beat issued this cycle has already left.
    if (flush) begin
      state_d = StEmpty;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_valid && !out_ready && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and scoreboarded checks of pipe_stage_skid. Two instances share the
// stimulus: one with default parameters, one narrow with a non-zero bubble
// value and a 4-bit stall counter to reach saturation quickly.
module tb_pipe_stage_skid;

  localparam int unsigned DW  = 102;
  localparam int unsigned SDW = 16;
  localparam logic [SDW-1:0] SBUB = 16'hbeef;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          cnt_clr;

  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [15:0]   stall_cnt;
  logic [1:0]    occupancy;

  logic           s_in_ready;
  logic           s_out_valid;
  logic [SDW-1:0] s_out_data;
  logic [3:0]     s_stall_cnt;
  logic [1:0]     s_occupancy;

  int n_checks;
  int n_errors;

  pipe_stage_skid u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt),
    .occupancy (occupancy)
  );

  pipe_stage_skid #(
    .DATA_W     (SDW),
    .BUBBLE_VAL (SBUB),
    .CNT_W      (4)
  ) u_dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data[SDW-1:0]),
    .in_ready  (s_in_ready),
    .out_valid (s_out_valid),
    .out_data  (s_out_data),
    .out_ready (out_ready),
    .cnt_clr   (cnt_clr),
    .stall_cnt (s_stall_cnt),
    .occupancy (s_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after
  // the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] sb[$];
  int            stall_model;
  logic          m_issue;
  logic          m_accept;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;

    // Reset state
    #13;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_s_out_data", s_out_data, SBUB);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_occupancy", occupancy, 0);
    rst_n = 1'b1;
    tick();

    // Streaming at full rate
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = DW'(i);
      tick();
      check("stream_data", out_data, 128'(i));
      check("stream_valid", out_valid, 1'b1);
      check("stream_in_ready", in_ready, 1'b1);
      check("stream_occ", occupancy, 1);
      check("stream_stall", stall_cnt, 0);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_valid", out_valid, 1'b0);
    check("stream_drain_occ", occupancy, 0);

    // Backpressure into the skid slot
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'('h11);
    tick();
    check("bp_a_occ", occupancy, 1);
    check("bp_a_data", out_data, 'h11);
    in_data = DW'('h22);
    tick();
    check("bp_b_occ", occupancy, 2);
    check("bp_b_in_ready", in_ready, 1'b0);
    check("bp_b_data", out_data, 'h11);
    check("bp_b_stall", stall_cnt, 1);
    in_valid = 1'b0;
    tick();
    check("bp_hold_data", out_data, 'h11);
    check("bp_hold_stall", stall_cnt, 2);
    out_ready = 1'b1;
    tick();
    check("bp_issue2_data", out_data, 'h22);
    check("bp_issue2_occ", occupancy, 1);
    check("bp_issue2_in_ready", in_ready, 1'b1);
    tick();
    check("bp_empty_valid", out_valid, 1'b0);
    check("bp_stall_total", stall_cnt, 2);

    // Flush while two beats are held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'('h44);
    tick();
    in_data = DW'('h55);
    tick();
    check("fl_pre_occ", occupancy, 2);
    flush   = 1'b1;
    in_data = DW'('h33);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", out_valid, 1'b0);
    check("fl_data", out_data, '0);
    check("fl_s_data", s_out_data, SBUB);
    check("fl_occ", occupancy, 0);
    check("fl_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_nothing_left", out_valid, 1'b0);
    end

    // Flush while one beat is held and a new beat is accepted
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'('h66);
    tick();
    flush   = 1'b1;
    in_data = DW'('h77);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl1_valid", out_valid, 1'b0);
    check("fl1_occ", occupancy, 0);
    tick();
    check("fl1_still_empty", out_valid, 1'b0);

    // Asynchronous reset from the SKID state, between edges
    in_valid = 1'b1;
    in_data  = DW'('h81);
    tick();
    in_data = DW'('h82);
    tick();
    in_valid = 1'b0;
    tick();
    check("ar_pre_occ", occupancy, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 1'b0);
    check("ar_in_ready", in_ready, 1'b1);
    check("ar_stall", stall_cnt, 0);
    check("ar_occ", occupancy, 0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = DW'('h90);
    tick();
    check("ar_first_valid", out_valid, 1'b1);
    check("ar_first_data", out_data, 'h90);
    in_valid = 1'b0;
    tick();
    check("ar_drained", out_valid, 1'b0);

    // Stall counter saturation on the 4-bit instance
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'('ha1);
    tick();
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("sat_cleared", s_stall_cnt, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) check("sat_at_15", s_stall_cnt, 15);
    end
    check("sat_hold", s_stall_cnt, 15);
    check("sat_wide_20", stall_cnt, 20);
    check("sat_data_held", out_data, 'ha1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("sat_clr", s_stall_cnt, 0);
    tick();
    check("sat_clr_then_1", s_stall_cnt, 1);
    out_ready = 1'b1;
    tick();
    check("sat_drained", out_valid, 1'b0);

    // Random handshake against a scoreboard
    cnt_clr = 1'b1;
    tick();
    cnt_clr     = 1'b0;
    stall_model = 0;
    sb.delete();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 5);
      in_data   = {38'($urandom), 32'($urandom), 32'($urandom)};
      check("rnd_occ", occupancy, 128'(sb.size()));
      check("rnd_out_valid", out_valid, sb.size() > 0);
      check("rnd_in_ready", in_ready, sb.size() < 2);
      if (sb.size() > 0) begin
        check("rnd_data", out_data, sb[0]);
        check("rnd_s_data", s_out_data, sb[0][SDW-1:0]);
      end else begin
        check("rnd_bubble", out_data, '0);
        check("rnd_s_bubble", s_out_data, SBUB);
      end
      m_issue  = (sb.size() > 0) && out_ready;
      m_accept = in_valid && (sb.size() < 2);
      if ((sb.size() > 0) && !out_ready) stall_model++;
      if (flush) begin
        sb.delete();
      end else begin
        if (m_issue) void'(sb.pop_front());
        if (m_accept) sb.push_back(in_data);
      end
      tick();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    check("rnd_stall_wide", stall_cnt, 128'(stall_model));
    check("rnd_stall_sat", s_stall_cnt, (stall_model > 15) ? 15 : stall_model);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
